// File: rtl/rx_audio_samp_src.sv
// rtl/rx_audio_samp_src.sv - audio/wideband sample source with audio-memory read handshake (optional RX_TICKS_EN tick stamp)
module rx_audio_samp_src #(
    parameter int WB_CYCLES = 6,
    parameter int DW        = 16
) (
    input  logic          adc_clk,
    input  logic          reset_n,
    input  logic          aud_valid,
    input  logic [DW-1:0] aud_i,
    input  logic [DW-1:0] aud_q,
    input  logic          wb_valid,
    input  logic [DW-1:0] wb_i,
    input  logic [DW-1:0] wb_q,
    input  logic          rd_getI,
    input  logic          rd_getQ,
    input  logic          rd_getWB,
    input  logic          clr_flags,
    output logic          rx_avail_A,
    output logic          rx_avail_wb_A,
    output logic [DW-1:0] rx_din_A,
    output logic          aud_ovfl,
    output logic          wb_ovfl,
    output logic          aud_miss,
    output logic          proto_err
`ifdef RX_TICKS_EN
    ,
    output logic [47:0]   ticks_A
`endif
);

    localparam logic [1:0] AIDLE = 2'd0;
    localparam logic [1:0] AI    = 2'd1;
    localparam logic [1:0] AQ    = 2'd2;

    localparam logic [1:0] WIDLE = 2'd0;
    localparam logic [1:0] WI    = 2'd1;
    localparam logic [1:0] WQ    = 2'd2;

    localparam logic [3:0] WB_LAST = 4'(WB_CYCLES - 1);

    logic [1:0]    aud_state;
    logic [1:0]    wb_state;
    logic [DW-1:0] aud_i_r;
    logic [DW-1:0] aud_q_r;
    logic          aud_pending;
    logic [DW-1:0] wb_i_r;
    logic [DW-1:0] wb_q_r;
    logic          wb_pending;
    logic [3:0]    wb_ctr;

    logic sel_i;
    logic sel_q;
    logic sel_wb;
    logic multi_get;
    logic aud_rd_i;
    logic aud_rd_q;
    logic wb_rd;
    logic wb_rd_q;
    logic bad_get;
    logic aud_load;
    logic aud_ovfl_set;
    logic wb_ovfl_set;
    logic slot_start;
    logic aud_announce;
    logic aud_miss_set;

    // Read arbitration: at most one strobe is served, I before Q before WB.
    always_comb begin
        sel_i     = rd_getI;
        sel_q     = rd_getQ & ~rd_getI;
        sel_wb    = rd_getWB & ~rd_getI & ~rd_getQ;
        multi_get = (rd_getI & rd_getQ) | (rd_getI & rd_getWB) | (rd_getQ & rd_getWB);
        aud_rd_i  = sel_i & (aud_state == AI);
        aud_rd_q  = sel_q & (aud_state == AQ);
        wb_rd     = sel_wb & ((wb_state == WI) | (wb_state == WQ));
        wb_rd_q   = sel_wb & (wb_state == WQ);
        bad_get   = multi_get | (sel_i & ~aud_rd_i) | (sel_q & ~aud_rd_q) | (sel_wb & ~wb_rd);
    end

    // Holding-register events; a completing Q read frees the slot in the same cycle.
    always_comb begin
        aud_load     = aud_valid & (~aud_pending | aud_rd_q);
        aud_ovfl_set = aud_valid & aud_pending & ~aud_rd_q;
        wb_ovfl_set  = wb_valid & wb_pending & ~wb_rd_q;
        slot_start   = wb_valid & (wb_ctr == 4'd0);
        // An already-announced sample is not offered again.
        aud_announce = slot_start & aud_pending & (aud_state == AIDLE);
        aud_miss_set = slot_start & ~aud_pending;
    end

    // Audio holding register and pending bit.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            aud_i_r     <= '0;
            aud_q_r     <= '0;
            aud_pending <= 1'b0;
        end else begin
            if (aud_load) begin
                aud_i_r     <= aud_i;
                aud_q_r     <= aud_q;
                aud_pending <= 1'b1;
            end else if (aud_rd_q) begin
                aud_pending <= 1'b0;
            end
        end
    end

    // Wideband holding register: newest sample always wins.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_i_r     <= '0;
            wb_q_r     <= '0;
            wb_pending <= 1'b0;
        end else begin
            if (wb_valid) begin
                wb_i_r     <= wb_i;
                wb_q_r     <= wb_q;
                wb_pending <= 1'b1;
            end else if (wb_rd_q) begin
                wb_pending <= 1'b0;
            end
        end
    end

    // Wideband slot counter: position of the next wideband sample within an audio slot.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_ctr <= 4'd0;
        end else if (wb_valid) begin
            wb_ctr <= (wb_ctr == WB_LAST) ? 4'd0 : wb_ctr + 4'd1;
        end
    end

    // Availability pulses, one cycle after the wideband strobe.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_avail_A    <= 1'b0;
            rx_avail_wb_A <= 1'b0;
        end else begin
            rx_avail_A    <= aud_announce;
            rx_avail_wb_A <= wb_valid;
        end
    end

    // Audio read FSM: announce, then I, then Q.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            aud_state <= AIDLE;
        end else begin
            case (aud_state)
                AIDLE:   if (rx_avail_A) aud_state <= AI;
                AI:      if (aud_rd_i)   aud_state <= AQ;
                AQ:      if (aud_rd_q)   aud_state <= AIDLE;
                default: aud_state <= AIDLE;
            endcase
        end
    end

    // Wideband read FSM: announce, then two WB reads (I then Q).
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_state <= WIDLE;
        end else begin
            case (wb_state)
                WIDLE:   if (rx_avail_wb_A) wb_state <= WI;
                WI:      if (wb_rd)         wb_state <= WQ;
                WQ:      if (wb_rd)         wb_state <= WIDLE;
                default: wb_state <= WIDLE;
            endcase
        end
    end

    // Read data register: updated only by a served read, otherwise holds.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_din_A <= '0;
        end else begin
            if (aud_rd_i) begin
                rx_din_A <= aud_i_r;
            end else if (aud_rd_q) begin
                rx_din_A <= aud_q_r;
            end else if (wb_rd) begin
                rx_din_A <= (wb_state == WI) ? wb_i_r : wb_q_r;
            end
        end
    end

    // Sticky status flags; a set in the same cycle as clr_flags takes precedence.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            aud_ovfl  <= 1'b0;
            wb_ovfl   <= 1'b0;
            aud_miss  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            aud_ovfl  <= aud_ovfl_set | (aud_ovfl  & ~clr_flags);
            wb_ovfl   <= wb_ovfl_set  | (wb_ovfl   & ~clr_flags);
            aud_miss  <= aud_miss_set | (aud_miss  & ~clr_flags);
            proto_err <= bad_get      | (proto_err & ~clr_flags);
        end
    end

`ifdef RX_TICKS_EN
    logic [47:0] tick_ctr;

    // Free-running tick counter; ticks_A is loaded with the value the counter shows during the rx_avail_A pulse.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_ctr <= '0;
            ticks_A  <= '0;
        end else begin
            tick_ctr <= tick_ctr + 48'd1;
            if (aud_announce) begin
                ticks_A <= tick_ctr + 48'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_audio_samp_src.sv
// tb/tb_rx_audio_samp_src.sv - self-checking bench for rx_audio_samp_src
module tb_rx_audio_samp_src;

    logic        adc_clk = 1'b0;
    logic        reset_n;
    logic        aud_valid;
    logic [15:0] aud_i;
    logic [15:0] aud_q;
    logic        wb_valid;
    logic [15:0] wb_i;
    logic [15:0] wb_q;
    logic        rd_getI;
    logic        rd_getQ;
    logic        rd_getWB;
    logic        clr_flags;
    logic        rx_avail_A;
    logic        rx_avail_wb_A;
    logic [15:0] rx_din_A;
    logic        aud_ovfl;
    logic        wb_ovfl;
    logic        aud_miss;
    logic        proto_err;
`ifdef RX_TICKS_EN
    logic [47:0] ticks_A;
    logic [47:0] tb_ticks;
`endif

    int total_cnt = 0;
    int pass_cnt  = 0;
    int n_a       = 0;
    int n_wb      = 0;
    int n_lone    = 0;

    rx_audio_samp_src #(.WB_CYCLES(6), .DW(16)) dut (
        .adc_clk       (adc_clk),
        .reset_n       (reset_n),
        .aud_valid     (aud_valid),
        .aud_i         (aud_i),
        .aud_q         (aud_q),
        .wb_valid      (wb_valid),
        .wb_i          (wb_i),
        .wb_q          (wb_q),
        .rd_getI       (rd_getI),
        .rd_getQ       (rd_getQ),
        .rd_getWB      (rd_getWB),
        .clr_flags     (clr_flags),
        .rx_avail_A    (rx_avail_A),
        .rx_avail_wb_A (rx_avail_wb_A),
        .rx_din_A      (rx_din_A),
        .aud_ovfl      (aud_ovfl),
        .wb_ovfl       (wb_ovfl),
        .aud_miss      (aud_miss),
        .proto_err     (proto_err)
`ifdef RX_TICKS_EN
        ,
        .ticks_A       (ticks_A)
`endif
    );

    always #5 adc_clk = ~adc_clk;

    typedef struct {
        logic        av;
        logic [15:0] ai;
        logic [15:0] aq;
        logic        wv;
        logic [15:0] wi;
        logic [15:0] wq;
        logic        gi;
        logic        gq;
        logic        gw;
        logic        clr;
        logic        e_av;
        logic        e_wav;
        logic [15:0] e_din;
        logic [3:0]  e_flg;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic av, input logic [15:0] ai, input logic [15:0] aq,
                       input logic wv, input logic [15:0] wi, input logic [15:0] wq,
                       input logic gi, input logic gq, input logic gw, input logic clr,
                       input logic e_av, input logic e_wav, input logic [15:0] e_din,
                       input logic [3:0] e_flg);
        vec_t v;
        v.av = av; v.ai = ai; v.aq = aq; v.wv = wv; v.wi = wi; v.wq = wq;
        v.gi = gi; v.gq = gq; v.gw = gw; v.clr = clr;
        v.e_av = e_av; v.e_wav = e_wav; v.e_din = e_din; v.e_flg = e_flg;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] outs();
        return {10'd0, rx_avail_A, rx_avail_wb_A, rx_din_A, aud_ovfl, wb_ovfl, aud_miss, proto_err};
    endfunction

    // Pulse counters and tick-stamp model, sampled on the falling edge.
`ifdef RX_TICKS_EN
    always @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) tb_ticks <= '0;
        else          tb_ticks <= tb_ticks + 48'd1;
    end
`endif

    always @(negedge adc_clk) begin
        if (reset_n) begin
            if (rx_avail_A) n_a++;
            if (rx_avail_wb_A) n_wb++;
            if (rx_avail_A && !rx_avail_wb_A) n_lone++;
`ifdef RX_TICKS_EN
            if (rx_avail_A) chk("ticks_A", ticks_A[31:0], tb_ticks[31:0]);
`endif
        end
    end

    // One audio sample (optional) followed by six wideband samples 34 cycles apart.
    task automatic seq_slot(input logic do_aud, input logic [15:0] si, input logic [15:0] sq,
                            input logic expect_first);
        n_a = 0; n_wb = 0; n_lone = 0;
        if (do_aud) begin
            aud_valid = 1'b1; aud_i = si; aud_q = sq;
            @(negedge adc_clk);
            aud_valid = 1'b0;
        end
        for (int k = 0; k < 6; k++) begin
            repeat (33) @(negedge adc_clk);
            wb_valid = 1'b1; wb_i = 16'hC000 + 16'(k); wb_q = 16'hD000 + 16'(k);
            @(negedge adc_clk);
            wb_valid = 1'b0;
            if (k == 0) chk("first_slot_pair", {30'd0, rx_avail_A, rx_avail_wb_A}, {30'd0, expect_first, 1'b1});
        end
        @(negedge adc_clk);
    endtask

    task automatic read_aud(input logic [15:0] ei, input logic [15:0] eq);
        rd_getI = 1'b1;
        @(negedge adc_clk);
        rd_getI = 1'b0;
        chk("read_I_latency", {16'd0, rx_din_A}, {16'd0, ei});
        rd_getQ = 1'b1;
        @(negedge adc_clk);
        rd_getQ = 1'b0;
        chk("read_Q_latency", {16'd0, rx_din_A}, {16'd0, eq});
    endtask

    initial begin
        reset_n = 1'b0; aud_valid = 1'b0; aud_i = '0; aud_q = '0;
        wb_valid = 1'b0; wb_i = '0; wb_q = '0;
        rd_getI = 1'b0; rd_getQ = 1'b0; rd_getWB = 1'b0; clr_flags = 1'b0;

        //  av  ai       aq       wv  wi       wq       gi gq gw clr  eav ewav edin     eflg{ao,wo,miss,pe}
        add(1, 16'h1234, 16'h5678, 0, 16'h0000, 16'h0000, 0, 0, 0, 0,  0, 0, 16'h0000, 4'b0000);
        add(0, 16'h0000, 16'h0000, 1, 16'hA001, 16'hB001, 0, 0, 0, 0,  1, 1, 16'h0000, 4'b0000);
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0,  0, 0, 16'h0000, 4'b0000);
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 0, 0,  0, 0, 16'h1234, 4'b0000);
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 0, 0,  0, 0, 16'h5678, 4'b0000);
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 1, 0,  0, 0, 16'hA001, 4'b0000);
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0,  0, 0, 16'hA001, 4'b0000);
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 1, 0,  0, 0, 16'hB001, 4'b0000);
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 0, 0,  0, 0, 16'hB001, 4'b0001);
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 1,  0, 0, 16'hB001, 4'b0000);
        add(0, 16'h0000, 16'h0000, 1, 16'hA002, 16'hB002, 0, 0, 0, 0,  0, 1, 16'hB001, 4'b0000);
        add(0, 16'h0000, 16'h0000, 1, 16'hA003, 16'hB003, 0, 0, 0, 0,  0, 1, 16'hB001, 4'b0100);
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 1, 1,  0, 0, 16'hA003, 4'b0000);
        add(0, 16'h0000, 16'h0000, 1, 16'hA004, 16'hB004, 0, 0, 1, 0,  0, 1, 16'hB003, 4'b0000);
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0,  0, 0, 16'hB003, 4'b0000);
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 1, 0,  0, 0, 16'hA004, 4'b0000);
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 1, 0,  0, 0, 16'hB004, 4'b0000);
        add(0, 16'h0000, 16'h0000, 1, 16'hA005, 16'hB005, 0, 0, 0, 0,  0, 1, 16'hB004, 4'b0000);
        add(0, 16'h0000, 16'h0000, 1, 16'hA006, 16'hB006, 0, 0, 0, 0,  0, 1, 16'hB004, 4'b0100);
        add(0, 16'h0000, 16'h0000, 1, 16'hA007, 16'hB007, 0, 0, 0, 0,  0, 1, 16'hB004, 4'b0110);
        add(1, 16'h1111, 16'h2222, 0, 16'h0000, 16'h0000, 0, 0, 0, 1,  0, 0, 16'hB004, 4'b0000);
        add(1, 16'h3333, 16'h4444, 0, 16'h0000, 16'h0000, 0, 0, 0, 0,  0, 0, 16'hB004, 4'b1000);
        for (int k = 0; k < 5; k++)
            add(0, 16'h0000, 16'h0000, 1, 16'hA008 + 16'(k), 16'hB008 + 16'(k), 0, 0, 0, 0,  0, 1, 16'hB004, 4'b1100);
        add(0, 16'h0000, 16'h0000, 1, 16'hA00D, 16'hB00D, 0, 0, 0, 0,  1, 1, 16'hB004, 4'b1100);
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0,  0, 0, 16'hB004, 4'b1100);
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 1, 1,  0, 0, 16'h1111, 4'b0001);
        add(1, 16'h7777, 16'h8888, 0, 16'h0000, 16'h0000, 0, 1, 0, 0,  0, 0, 16'h2222, 4'b0001);
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 1, 0,  0, 0, 16'hA00D, 4'b0001);
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 1, 1,  0, 0, 16'hA00D, 4'b0001);
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 1, 1,  0, 0, 16'hB00D, 4'b0000);
        add(1, 16'h9999, 16'hAAAA, 0, 16'h0000, 16'h0000, 0, 0, 0, 0,  0, 0, 16'hB00D, 4'b1000);

        repeat (3) @(negedge adc_clk);
        chk("reset_state", outs(), 32'd0);
        reset_n = 1'b1;

        foreach (tbl[r]) begin
            aud_valid = tbl[r].av; aud_i = tbl[r].ai; aud_q = tbl[r].aq;
            wb_valid = tbl[r].wv; wb_i = tbl[r].wi; wb_q = tbl[r].wq;
            rd_getI = tbl[r].gi; rd_getQ = tbl[r].gq; rd_getWB = tbl[r].gw; clr_flags = tbl[r].clr;
            @(negedge adc_clk);
            chk($sformatf("vec%0d", r), outs(),
                {10'd0, tbl[r].e_av, tbl[r].e_wav, tbl[r].e_din, tbl[r].e_flg});
        end
        aud_valid = 1'b0; wb_valid = 1'b0; rd_getI = 1'b0; rd_getQ = 1'b0; rd_getWB = 1'b0; clr_flags = 1'b0;

        reset_n = 1'b0;
        @(negedge adc_clk);
        reset_n = 1'b1;

        seq_slot(1'b1, 16'h1234, 16'h5678, 1'b1);
        chk("slot_aud_pulses", n_a, 1);
        chk("slot_wb_pulses", n_wb, 6);
        chk("slot_lone_aud", n_lone, 0);
        read_aud(16'h1234, 16'h5678);

        seq_slot(1'b1, 16'hAAAA, 16'hBBBB, 1'b1);
        chk("unread_first_pulses", n_a, 1);
        seq_slot(1'b0, 16'h0000, 16'h0000, 1'b0);
        chk("unread_no_repeat", n_a, 0);
        chk("unread_no_miss", {31'd0, aud_miss}, 32'd0);

        rd_getWB = 1'b1; wb_valid = 1'b1; wb_i = 16'hE123; wb_q = 16'hF456;
        @(negedge adc_clk);
        rd_getWB = 1'b0; wb_valid = 1'b0;
        chk("wq_entry", {15'd0, rx_avail_wb_A, rx_din_A}, {15'd0, 1'b1, 16'hC005});
        #2 reset_n = 1'b0;
        #1 chk("async_reset_outs", outs(), 32'd0);
        @(negedge adc_clk);
        @(negedge adc_clk);
        reset_n = 1'b1;

        seq_slot(1'b1, 16'h1234, 16'h5678, 1'b1);
        chk("post_reset_aud_pulses", n_a, 1);
        chk("post_reset_wb_pulses", n_wb, 6);
        read_aud(16'h1234, 16'h5678);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rx_audio_samp_src.md
RX_AUDIO_SAMP_SRC -- requirements
Module: rx_audio_samp_src

Interface
REQ-001 Parameter WB_CYCLES, default 6: wideband samples per audio-sample slot; legal range 2..15.
REQ-002 Parameter DW, default 16: width of the sample words and of rx_din_A.
REQ-003 Port adc_clk  in  1  the only clock; all logic rising-edge.
REQ-004 Port reset_n  in  1  asynchronous, active-low reset.
REQ-005 Ports:
- aud_valid  in  1  one-cycle strobe: new audio I/Q on aud_i/aud_q.
- aud_i, aud_q  in  DW  audio sample.
- wb_valid  in  1  one-cycle strobe: new wideband I/Q on wb_i/wb_q.
- wb_i, wb_q  in  DW  wideband sample.
REQ-006 Ports rd_getI, rd_getQ, rd_getWB  in  1  sink read strobes, one word per strobe.
REQ-007 Ports rx_avail_A, rx_avail_wb_A  out  1  one-cycle availability pulses to the audio-memory sink.
REQ-008 Port rx_din_A  out  DW  registered read data.
REQ-009 Ports aud_ovfl, wb_ovfl, aud_miss, proto_err  out  1  sticky status flags.
REQ-010 Port clr_flags  in  1  synchronous clear of all sticky flags.

Function
REQ-011 An audio holding register (I, Q, pending bit) shall load on aud_valid when not pending.
REQ-012 aud_valid while pending shall drop the new sample, keep the held one and set aud_ovfl.
REQ-013 A wideband holding register shall load on wb_valid and set wb_pending.
REQ-014 wb_valid while wb_pending shall overwrite the held sample and set wb_ovfl.
REQ-015 wb_ctr, 4 bits, 0..WB_CYCLES-1, shall advance on each accepted wb_valid and wrap to 0 after WB_CYCLES-1.
REQ-016 The cycle after wb_valid, rx_avail_wb_A shall pulse high for exactly one cycle.
REQ-017 If wb_ctr was 0 at that wb_valid and audio was pending, rx_avail_A shall pulse in the same cycle as rx_avail_wb_A.
REQ-018 If wb_ctr was 0 and audio was not pending, no rx_avail_A pulse occurs and aud_miss shall set.
REQ-019 Audio read FSM:
- AIDLE -> AI on rx_avail_A.
- AI -> AQ on rd_getI; rx_din_A<=I next cycle.
- AQ -> AIDLE on rd_getQ; rx_din_A<=Q, pending cleared.
REQ-020 WB read FSM:
- WIDLE -> WI on rx_avail_wb_A.
- WI -> WQ on rd_getWB; rx_din_A<=wb_i.
- WQ -> WIDLE on rd_getWB; rx_din_A<=wb_q, wb_pending cleared.
REQ-021 Read latency shall be exactly 1 cycle, strobe to rx_din_A; rx_din_A holds its value between reads.
REQ-022 More than one get strobe in a cycle shall serve priority I > Q > WB, drop the others and set proto_err.
REQ-023 A strobe not legal in the current FSM state shall be ignored, leave rx_din_A unchanged and set proto_err.
REQ-024 aud_valid and an AQ read completing in the same cycle shall load the new sample with no overflow.
REQ-025 The same-cycle rule of REQ-024 shall apply to wb_valid and a WQ read completing.
REQ-026 clr_flags and a flag-set event in the same cycle: the set shall win.

Reset
REQ-027 reset_n low shall immediately force: both FSMs idle, pending bits 0, wb_ctr 0, all flags 0.
REQ-028 reset_n low shall immediately force rx_avail_A=0, rx_avail_wb_A=0 and rx_din_A=0.
REQ-029 Reset asserted mid-read shall abandon the read; after release the first wb_valid shall be treated as wb_ctr 0.

Configuration
REQ-030 Macro RX_TICKS_EN:
- Defined: adds 48-bit free-running tick counter (reset 0) and output ticks_A [47:0], latched at each rx_avail_A pulse.
- Defined: ticks_A reset value 0; it shall hold between rx_avail_A pulses.
- Undefined: no counter and no ticks_A port; all other behaviour identical.

Verification
REQ-031 aud_valid(I=0x1234,Q=0x5678), then 6 wb_valid, 34 cycles apart -> one rx_avail_A with the first rx_avail_wb_A; 6 rx_avail_wb_A in total.
REQ-032 Continuing REQ-031, rd_getI then rd_getQ -> rx_din_A = 0x1234 then 0x5678, each 1 cycle after its strobe.
REQ-033 Two aud_valid, no reads -> first sample retained; aud_ovfl=1.
REQ-034 Audio sample never read -> no rx_avail_A at the next wb_ctr=0.
REQ-035 No aud_valid before wb_ctr returns to 0 -> no rx_avail_A; aud_miss=1.
REQ-036 rd_getI and rd_getWB same cycle -> I served; proto_err=1.
REQ-037 reset_n low during WQ -> outputs 0 immediately; sequence of REQ-031 passes after release.
REQ-038 With RX_TICKS_EN: ticks_A equals the counter value at each rx_avail_A; rerun REQ-031 to confirm.
